// File: rtl/led_cmd_pkg.sv
// Shared constants, FSM state encoding and argument range check for the
// LED command parser.
package led_cmd_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hAA;
  localparam logic [7:0] CMD_LED  = 8'h01;
  localparam logic [7:0] CMD_DUTY = 8'h02;
  localparam logic [7:0] CMD_MOVE = 8'h03;
  localparam logic [7:0] RSP_ACK  = 8'h55;
  localparam logic [7:0] RSP_NACK = 8'hEE;
  localparam logic [3:0] DUTY_MIN = 4'd1;
  localparam logic [3:0] DUTY_MAX = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GOT_HDR = 2'd1,
    ST_GOT_CMD = 2'd2,
    ST_GOT_ARG = 2'd3
  } state_t;

  // True when cmd is known and arg lies inside that command's legal range.
  function automatic logic arg_ok(input logic [7:0] cmd, input logic [7:0] arg);
    logic ok;
    case (cmd)
      CMD_LED:  ok = (arg[7:5] == 3'd0);
      CMD_DUTY: ok = (arg >= {4'd0, DUTY_MIN}) && (arg <= {4'd0, DUTY_MAX});
      CMD_MOVE: ok = (arg[7:1] == 7'd0);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/led_cmd_parser.sv
// UART command frame parser (AA CMD ARG CHK) driving LED pattern, duty and
// scroll-mode registers, with a depth-1 ACK/NACK response buffer.
// Optional inter-byte timeout is enabled by defining LED_CMD_TIMEOUT_EN.
module led_cmd_parser
  import led_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [4:0] led_state,
  output logic [3:0] duty_state,
  output logic       move_mode,
  output logic       cmd_err
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cmd;
  logic [7:0] r_arg;
  logic [4:0] r_led;
  logic [3:0] r_duty;
  logic       r_move;
  logic       r_err;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       w_frame_done;
  logic       w_frame_ok;
  logic       w_timeout;
  logic       w_buf_free;

`ifdef LED_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = (r_state != ST_IDLE) && !rx_valid &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle-cycle counter, only running while a frame is partially received.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (rx_valid || (r_state == ST_IDLE) || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_frame_ok = ((r_cmd ^ r_arg) == rx_data) && arg_ok(r_cmd, r_arg);
  // A response finishing this cycle frees the slot for the incoming one.
  assign w_buf_free = !r_tx_valid || tx_ready;

  // Next-state logic; 0xAA after the header is plain data.
  always_comb begin
    w_next       = r_state;
    w_frame_done = 1'b0;
    if (w_timeout) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rx_valid && (rx_data == HDR_BYTE)) w_next = ST_GOT_HDR;
          else                                   w_next = ST_IDLE;
        end
        ST_GOT_HDR: begin
          if (rx_valid) w_next = ST_GOT_CMD;
          else          w_next = ST_GOT_HDR;
        end
        ST_GOT_CMD: begin
          if (rx_valid) w_next = ST_GOT_ARG;
          else          w_next = ST_GOT_CMD;
        end
        ST_GOT_ARG: begin
          if (rx_valid) begin
            w_next       = ST_IDLE;
            w_frame_done = 1'b1;
          end else begin
            w_next       = ST_GOT_ARG;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Capture CMD and ARG bytes as they arrive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd <= 8'h00;
      r_arg <= 8'h00;
    end else begin
      if (rx_valid && (r_state == ST_GOT_HDR)) r_cmd <= rx_data;
      if (rx_valid && (r_state == ST_GOT_CMD)) r_arg <= rx_data;
    end
  end

  // Apply a validated command and flag rejected or aborted frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_led  <= 5'd0;
      r_duty <= DUTY_MIN;
      r_move <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= (w_frame_done && !w_frame_ok) || w_timeout;
      if (w_frame_done && w_frame_ok) begin
        case (r_cmd)
          CMD_LED:  r_led  <= r_arg[4:0];
          CMD_DUTY: r_duty <= r_arg[3:0];
          CMD_MOVE: r_move <= r_arg[0];
          default:  r_led  <= r_led;
        endcase
      end
    end
  end

  // Depth-1 response buffer; a response arriving while full is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_frame_done && w_buf_free) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_frame_ok ? RSP_ACK : RSP_NACK;
    end else if (r_tx_valid && tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign led_state  = r_led;
  assign duty_state = r_duty;
  assign move_mode  = r_move;
  assign cmd_err    = r_err;

endmodule
